// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lu_pkg
//  Purpose  : Shared sizes, element indexing and FSM state type for the
//             4x4 LU decomposer / inverse pipeline.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lu_pkg;

  localparam int N        = 4;
  localparam int WORD     = 32;
  localparam int MAT_BITS = N * N * WORD;

  // Flat element index of matrix entry (r,c) in a packed row-major bus
  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_F_ACC    = 3'd1,
    S_F_STORE  = 3'd2,
    S_B_ACC    = 3'd3,
    S_B_STORE  = 3'd4,
    S_NEXT_COL = 3'd5,
    S_DONE     = 3'd6
  } inv_state_t;

endpackage
`default_nettype wire

// File: rtl/lu_inv_mac.sv
`default_nettype none
// ============================================================================
//  Module   : lu_inv_mac
//  Purpose  : Signed 32x32 multiply feeding a 64-bit accumulator.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             i_clr         clear accumulator (priority over i_en)
//             i_en          add i_a*i_b to accumulator
//             i_a, i_b      signed 32-bit operands
//             o_acc         signed 64-bit accumulator value
//  Revision : 1.0  initial release
// ============================================================================
module lu_inv_mac
  import lu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic signed [WORD-1:0]     i_a,
  input  logic signed [WORD-1:0]     i_b,
  output logic signed [2*WORD-1:0]   o_acc
);

  logic signed [2*WORD-1:0] w_prod;
  logic signed [2*WORD-1:0] r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lu_inverse_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : lu_inverse_4x4
//  Purpose  : Computes A^-1 = U^-1 * L^-1 column by column: forward solve
//             L*y = e_c, then backward solve U*x = y, using one shared MAC.
//             Result is signed fixed point with FRAC_BITS fractional bits.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             start         request, sampled only while idle
//             L_in, U_in    packed 4x4 signed 32-bit matrices, (r,c) at
//                           bits [(r*4+c)*32 +: 32]
//             busy          run in progress
//             done          one-cycle pulse, inv_out/err valid
//             err           zero pivot seen during the last run
//             inv_out       inverse, same packing, held until next done
//  Revision : 1.0  initial release
// ============================================================================
module lu_inverse_4x4
  import lu_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MAT_BITS-1:0] L_in,
  input  logic [MAT_BITS-1:0] U_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [MAT_BITS-1:0] inv_out
);

  inv_state_t                r_state;
  logic [MAT_BITS-1:0]       r_l;
  logic [MAT_BITS-1:0]       r_u;
  logic [MAT_BITS-1:0]       r_res;
  logic [MAT_BITS-1:0]       r_inv;
  logic signed [WORD-1:0]    r_y [N];
  logic signed [WORD-1:0]    r_x [N];
  logic [1:0]                r_c;
  logic [1:0]                r_i;
  logic [1:0]                r_m;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;

  logic signed [WORD-1:0]    w_mac_a;
  logic signed [WORD-1:0]    w_mac_b;
  logic                      w_mac_en;
  logic                      w_mac_clr;
  logic signed [2*WORD-1:0]  w_acc;

  logic signed [2*WORD-1:0]  w_e;
  logic signed [WORD-1:0]    w_y_new;
  logic signed [WORD-1:0]    w_y_i;
  logic signed [WORD-1:0]    w_piv;
  logic                      w_piv_zero;
  logic signed [2*WORD-1:0]  w_num;
  logic signed [2*WORD-1:0]  w_den;
  logic signed [WORD-1:0]    w_x_new;

  // MAC operands: L row / y vector when going forward, U row / x going back
  assign w_mac_en  = (r_state == S_F_ACC) || (r_state == S_B_ACC);
  assign w_mac_clr = (r_state == S_IDLE) || (r_state == S_F_STORE) ||
                     (r_state == S_B_STORE);
  assign w_mac_a   = (r_state == S_F_ACC) ? r_l[idx(int'(r_i), int'(r_m))*WORD +: WORD]
                                          : r_u[idx(int'(r_i), int'(r_m))*WORD +: WORD];
  assign w_mac_b   = (r_state == S_F_ACC) ? r_y[r_m] : r_x[r_m];

  lu_inv_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (w_mac_a),
    .i_b   (w_mac_b),
    .o_acc (w_acc)
  );

  // Forward store: unit vector entry scaled to fixed point, minus the sum
  assign w_e     = (r_i == r_c) ? (64'sd1 <<< FRAC_BITS) : 64'sd0;
  assign w_y_new = WORD'(w_e - w_acc);

  // Backward store: 64-bit signed divide, zero pivot forces a zero result
  assign w_y_i      = r_y[r_i];
  assign w_piv      = r_u[idx(int'(r_i), int'(r_i))*WORD +: WORD];
  assign w_piv_zero = (w_piv == '0);
  assign w_num      = {{WORD{w_y_i[WORD-1]}}, w_y_i} - w_acc;
  assign w_den      = w_piv_zero ? 64'sd1 : {{WORD{w_piv[WORD-1]}}, w_piv};
  assign w_x_new    = w_piv_zero ? '0 : WORD'(w_num / w_den);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_l     <= '0;
      r_u     <= '0;
      r_res   <= '0;
      r_inv   <= '0;
      r_c     <= '0;
      r_i     <= '0;
      r_m     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_y[k] <= '0;
        r_x[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_l     <= L_in;
            r_u     <= U_in;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_c     <= '0;
            r_i     <= '0;
            r_m     <= '0;
            r_state <= S_F_STORE;   // row 0 has no sub-diagonal terms
          end
        end
        S_F_ACC: begin
          if (r_m == r_i - 2'd1) r_state <= S_F_STORE;
          else                   r_m     <= r_m + 2'd1;
        end
        S_F_STORE: begin
          r_y[r_i] <= w_y_new;
          if (r_i == 2'd3) begin
            r_state <= S_B_STORE;   // backward row 3 has no terms
          end else begin
            r_i     <= r_i + 2'd1;
            r_m     <= '0;
            r_state <= S_F_ACC;
          end
        end
        S_B_ACC: begin
          if (r_m == 2'd3) r_state <= S_B_STORE;
          else             r_m     <= r_m + 2'd1;
        end
        S_B_STORE: begin
          r_x[r_i] <= w_x_new;
          if (w_piv_zero) r_err <= 1'b1;
          if (r_i == 2'd0) begin
            r_state <= S_NEXT_COL;
          end else begin
            r_i     <= r_i - 2'd1;
            r_m     <= r_i;         // first term of row i-1 is column i
            r_state <= S_B_ACC;
          end
        end
        S_NEXT_COL: begin
          for (int r = 0; r < N; r++) begin
            r_res[idx(r, int'(r_c))*WORD +: WORD] <= r_x[r];
          end
          if (r_c == 2'd3) begin
            r_state <= S_DONE;
          end else begin
            r_c     <= r_c + 2'd1;
            r_i     <= '0;
            r_m     <= '0;
            r_state <= S_F_STORE;
          end
        end
        S_DONE: begin
          r_inv   <= r_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign inv_out = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_lu_inverse_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lu_inverse_4x4
//  Purpose  : Scoreboard bench for lu_inverse_4x4: directed and random L/U
//             pairs, reference inverse from plain substitution arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lu_inverse_4x4;

  localparam int FRAC = 16;
  localparam int LAT  = 85;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [511:0] L_in = '0;
  logic [511:0] U_in = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [511:0] inv_out;

  lu_inverse_4x4 #(.FRAC_BITS(FRAC)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .L_in    (L_in),
    .U_in    (U_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .inv_out (inv_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] inv;
    logic         err;
    int           st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint el(input logic [511:0] m, input int r, input int c);
    logic [31:0] w;
    w = m[(r*4+c)*32 +: 32];
    return longint'($signed(w));
  endfunction

  function automatic longint s32(input longint v);
    logic [31:0] w;
    w = v[31:0];
    return longint'($signed(w));
  endfunction

  // returns {err, inverse}
  function automatic logic [512:0] ref_inv(input logic [511:0] lm, input logic [511:0] um);
    logic [511:0] res;
    logic         e;
    longint       y[4];
    longint       x[4];
    longint       s;
    longint       d;
    res = '0;
    e   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        s = (i == c) ? (longint'(1) << FRAC) : 0;
        for (int m = 0; m < i; m++) s = s - el(lm, i, m) * y[m];
        y[i] = s32(s);
      end
      for (int i = 3; i >= 0; i--) begin
        s = y[i];
        for (int m = i + 1; m < 4; m++) s = s - el(um, i, m) * x[m];
        d = el(um, i, i);
        if (d == 0) begin
          x[i] = 0;
          e    = 1'b1;
        end else begin
          x[i] = s32(s / d);
        end
      end
      for (int r = 0; r < 4; r++) res[(r*4+c)*32 +: 32] = x[r][31:0];
    end
    return {e, res};
  endfunction

  // ---------------- matrix helpers ----------------
  function automatic logic [511:0] ident(input logic [31:0] one);
    logic [511:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) m[(k*5)*32 +: 32] = one;
    return m;
  endfunction

  // Unused triangles are filled with random garbage
  function automatic logic [511:0] rand_mat(input bit is_l);
    logic [511:0] m;
    int           v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[(r*4+c)*32 +: 32] = $urandom;
        if (is_l && c < r) begin
          v = int'($urandom_range(0, 6)) - 3;
          m[(r*4+c)*32 +: 32] = 32'(v);
        end else if (!is_l && c > r) begin
          v = int'($urandom_range(0, 8)) - 4;
          m[(r*4+c)*32 +: 32] = 32'(v);
        end else if (!is_l && c == r) begin
          v = int'($urandom_range(1, 7));
          if ($urandom_range(0, 1) == 1) v = -v;
          if ($urandom_range(0, 11) == 0) v = 0;
          m[(r*4+c)*32 +: 32] = 32'(v);
        end
      end
    end
    return m;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("inv_out", inv_out, e.inv);
        chk("err", {511'd0, err}, {511'd0, e.err});
        chk("latency", 512'(cyc - e.st), 512'(LAT));
        chk("busy_at_done", {511'd0, busy}, 512'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered at a negedge; returns at the negedge where done is seen.
  task automatic run(input logic [511:0] lm, input logic [511:0] um,
                     input logic [511:0] ei, input logic ee, input bit poke);
    exp_t e;
    bit   seen;
    L_in  = lm;
    U_in  = um;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.inv = ei;
    e.err = ee;
    e.st  = cyc;
    sb.push_back(e);
    chk("busy_after_start", {511'd0, busy}, {511'd0, 1'b1});
    if (poke) begin
      repeat (20) @(negedge clk);
      L_in  = rand_mat(1'b1);
      U_in  = rand_mat(1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 150 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: done=0 after 150 cycles, expected pulse");
      sb.delete();
    end
  endtask

  task automatic run_ref(input logic [511:0] lm, input logic [511:0] um, input bit poke);
    logic [512:0] r;
    r = ref_inv(lm, um);
    run(lm, um, r[511:0], r[512], poke);
  endtask

  logic [511:0] lm, um, ex;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {511'd0, busy}, 512'd0);
    chk("reset_done", {511'd0, done}, 512'd0);
    chk("reset_err", {511'd0, err}, 512'd0);
    chk("reset_inv", inv_out, 512'd0);

    // Identity
    run(ident(32'd1), ident(32'd1), ident(32'h0001_0000), 1'b0, 1'b0);

    // U = diag(2,4,1,1)
    um = ident(32'd1);
    um[(0*5)*32 +: 32] = 32'd2;
    um[(1*5)*32 +: 32] = 32'd4;
    ex = ident(32'h0001_0000);
    ex[(0*5)*32 +: 32] = 32'h0000_8000;
    ex[(1*5)*32 +: 32] = 32'h0000_4000;
    run(ident(32'd1), um, ex, 1'b0, 1'b0);

    // L[1][0] = 2
    lm = ident(32'd1);
    lm[(1*4+0)*32 +: 32] = 32'd2;
    ex = ident(32'h0001_0000);
    ex[(1*4+0)*32 +: 32] = 32'hFFFE_0000;
    run(lm, ident(32'd1), ex, 1'b0, 1'b0);

    // U[0][1] = 1, with a start pulse during busy that must be ignored
    um = ident(32'd1);
    um[(0*4+1)*32 +: 32] = 32'd1;
    ex = ident(32'h0001_0000);
    ex[(0*4+1)*32 +: 32] = 32'hFFFF_0000;
    run(ident(32'd1), um, ex, 1'b0, 1'b1);

    // Zero pivot U[2][2]
    um = ident(32'd1);
    um[(2*5)*32 +: 32] = 32'd0;
    ex = ident(32'h0001_0000);
    ex[(2*5)*32 +: 32] = 32'd0;
    run(ident(32'd1), um, ex, 1'b1, 1'b0);

    // Random back-to-back runs
    for (int t = 0; t < 20; t++) run_ref(rand_mat(1'b1), rand_mat(1'b0), (t % 7) == 3);

    // Reset 40 cycles into a run: no done, outputs cleared
    L_in  = rand_mat(1'b1);
    U_in  = rand_mat(1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {511'd0, busy}, 512'd0);
    chk("midrst_done", {511'd0, done}, 512'd0);
    chk("midrst_err", {511'd0, err}, 512'd0);
    chk("midrst_inv", inv_out, 512'd0);
    repeat (100) @(negedge clk);
    chk("midrst_inv_held", inv_out, 512'd0);

    // Normal operation after abort
    run_ref(rand_mat(1'b1), rand_mat(1'b0), 1'b0);
    run(ident(32'd1), ident(32'd1), ident(32'h0001_0000), 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
